bcd_conv_sched: RTL and testbench

- Multi-cycle binary-to-BCD converter with a scheduler that shares it between two requesters: req0 is the ring-oscillator frequency counter and req1 is a host/debug value source.
- Performs one shift-add-3 (double-dabble) step per clock, so a conversion takes BIN_W cycles instead of one long combinational chain.
- Uses a req/ack/valid handshake with round-robin arbitration and saturates at the decimal display range.
- Output digits feed the 7-segment display mux.

---
 rtl/bcd_conv_sched_pkg.sv | 25 ++
 rtl/bcd_conv_sched_dabble.sv | 28 ++
 rtl/bcd_conv_sched.sv | 137 +++++++++++++
 tb/tb_bcd_conv_sched.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_conv_sched_pkg.sv
// Shared types and constants for the time-multiplexed binary-to-BCD converter.
// Imported by the scheduler and its combinational double-dabble step.
package bcd_conv_sched_pkg;

  localparam int BIN_W_DEF = 16;
  localparam int NDIG_DEF  = 4;

  typedef logic [3:0] bcd_t;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  // Largest value that fits in ndig decimal digits (10**ndig - 1).
  function automatic longint max_val(input int ndig);
    longint m;
    m = 1;
    for (int i = 0; i < ndig; i++) begin
      m = m * 10;
    end
    return m - 1;
  endfunction

endpackage

// File: rtl/bcd_conv_sched_dabble.sv
// One double-dabble step: add 3 to every digit >= 5, then shift the digit
// chain left by one bit with bit_in entering the units digit. Purely combinational.
module bcd_dabble_step
  import bcd_conv_sched_pkg::*;
#(
  parameter int NDIG = NDIG_DEF
) (
  input  bcd_t [NDIG-1:0] din,
  input  logic            bit_in,
  output bcd_t [NDIG-1:0] dout
);

  bcd_t [NDIG-1:0]   adj;
  logic [4*NDIG-1:0] flat;

  always_comb begin
    adj = din;
    for (int i = 0; i < NDIG; i++) begin
      if (din[i] >= 4'd5) begin
        adj[i] = din[i] + 4'd3;
      end
    end
    flat = adj;
    // The MSB of each digit falls into the LSB of the next one up.
    dout = {flat[4*NDIG-2:0], bit_in};
  end

endmodule

// File: rtl/bcd_conv_sched.sv
// Round-robin scheduler sharing one bit-serial binary-to-BCD converter between
// two requesters; BIN_W steps per conversion, result saturates to all 9s.
module bcd_conv_sched
  import bcd_conv_sched_pkg::*;
#(
  parameter int BIN_W = BIN_W_DEF,
  parameter int NDIG  = NDIG_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [BIN_W-1:0] bin0,
  input  logic             req1,
  input  logic [BIN_W-1:0] bin1,
  output logic             ack0,
  output logic             ack1,
  output logic             busy,
  output logic             valid,
  output logic             src,
  output logic             ovf,
  output logic [3:0]       un,
  output logic [3:0]       dec,
  output logic [3:0]       cent,
  output logic [3:0]       milh
);

  localparam longint MAXV = max_val(NDIG);
  localparam int     CW   = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  state_t           state, state_nx;
  logic             last_grant;
  logic             grant, gnt_idx, tie, step_last;
  logic [BIN_W-1:0] shreg, gnt_bin;
  logic [CW-1:0]    cnt;
  logic             povf, psrc;
  bcd_t [NDIG-1:0]  acc, acc_nx, fin;

  bcd_dabble_step #(.NDIG(NDIG)) u_step (
    .din    (acc),
    .bit_in (shreg[BIN_W-1]),
    .dout   (acc_nx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    grant     = 1'b0;
    gnt_idx   = 1'b0;
    tie       = 1'b0;
    step_last = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          grant    = 1'b1;
          state_nx = CONV;
          if (req0 && req1) begin
            tie     = 1'b1;
            gnt_idx = ~last_grant;
          end else begin
            gnt_idx = req1;
          end
        end
      end
      CONV: begin
        if (cnt == '0) begin
          step_last = 1'b1;
          state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign gnt_bin = gnt_idx ? bin1 : bin0;
  assign fin     = povf ? {NDIG{4'd9}} : acc_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
      shreg      <= '0;
      cnt        <= '0;
      acc        <= '0;
      povf       <= 1'b0;
      psrc       <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      busy       <= 1'b0;
      valid      <= 1'b0;
      src        <= 1'b0;
      ovf        <= 1'b0;
      un         <= '0;
      dec        <= '0;
      cent       <= '0;
      milh       <= '0;
    end else begin
      ack0  <= 1'b0;
      ack1  <= 1'b0;
      valid <= 1'b0;
      if (grant) begin
        shreg <= gnt_bin;
        acc   <= '0;
        cnt   <= CW'(BIN_W - 1);
        ack0  <= ~gnt_idx;
        ack1  <= gnt_idx;
        busy  <= 1'b1;
        povf  <= (longint'(gnt_bin) > MAXV);
        psrc  <= gnt_idx;
        // Fairness state only moves when there was a real contest.
        if (tie) begin
          last_grant <= gnt_idx;
        end
      end else if (state == CONV) begin
        acc   <= acc_nx;
        shreg <= {shreg[BIN_W-2:0], 1'b0};
        cnt   <= cnt - 1'b1;
        if (step_last) begin
          un    <= fin[0];
          dec   <= fin[1];
          cent  <= fin[2];
          milh  <= fin[3];
          ovf   <= povf;
          src   <= psrc;
          valid <= 1'b1;
          busy  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Directed plus randomized bench for bcd_conv_sched; expected digits come from
// plain decimal arithmetic on the requested value.
module tb_bcd_conv_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [15:0] bin0 = '0, bin1 = '0;
  logic        ack0, ack1, busy, valid, src, ovf;
  logic [3:0]  un, dec, cent, milh;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_conv_sched dut (
    .clk  (clk),
    .rst  (rst),
    .req0 (req0),
    .bin0 (bin0),
    .req1 (req1),
    .bin1 (bin1),
    .ack0 (ack0),
    .ack1 (ack1),
    .busy (busy),
    .valid(valid),
    .src  (src),
    .ovf  (ovf),
    .un   (un),
    .dec  (dec),
    .cent (cent),
    .milh (milh)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_bcd(input int v);
    int s;
    s = (v > 9999) ? 9999 : v;
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic who, input int v);
    if (who) begin
      bin1 = 16'(v);
      req1 = 1'b1;
    end else begin
      bin0 = 16'(v);
      req0 = 1'b1;
    end
  endtask

  task automatic wait_ack(input string tag, input logic who, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(ack0 || ack1) && n < 40);
    chk({tag, "_ack"}, 32'({ack1, ack0}), who ? 32'h2 : 32'h1);
    chk({tag, "_busy_at_ack"}, 32'(busy), 32'h1);
  endtask

  task automatic wait_valid(input string tag, input int v, input logic who,
                            output int n, output int busyc);
    int stray;
    n = 0;
    busyc = 0;
    stray = 0;
    if (busy) busyc++;
    do begin
      tick();
      n++;
      if (ack0 || ack1) stray++;
      if (busy && !valid) busyc++;
    end while (!valid && n < 40);
    chk({tag, "_valid"}, 32'(valid), 32'h1);
    chk({tag, "_digits"}, 32'({milh, cent, dec, un}), 32'(ref_bcd(v)));
    chk({tag, "_ovf"}, 32'(ovf), (v > 9999) ? 32'h1 : 32'h0);
    chk({tag, "_src"}, 32'(src), 32'(who));
    chk({tag, "_busy_done"}, 32'(busy), 32'h0);
    chk({tag, "_stray_ack"}, 32'(stray), 32'h0);
  endtask

  task automatic run_one(input string tag, input logic who, input int v);
    int n, nv, bc;
    set_req(who, v);
    wait_ack(tag, who, n);
    chk({tag, "_ack_lat"}, 32'(n), 32'h1);
    req0 = 1'b0;
    req1 = 1'b0;
    wait_valid(tag, v, who, nv, bc);
    chk({tag, "_valid_lat"}, 32'(nv), 32'd16);
    chk({tag, "_busy_cycles"}, 32'(bc), 32'd16);
    tick();
    chk({tag, "_valid_pulse"}, 32'(valid), 32'h0);
    chk({tag, "_hold"}, 32'({milh, cent, dec, un}), 32'(ref_bcd(v)));
  endtask

  initial begin
    int n, n2, bc, v, va, vb, vcnt;
    logic who;

    rst = 1'b1;
    tick();
    tick();
    chk("reset_outputs",
        32'({ack0, ack1, busy, valid, src, ovf, milh, cent, dec, un}), 32'h0);
    rst = 1'b0;
    tick();

    run_one("basic1234", 1'b0, 1234);

    run_one("b_zero", 1'b1, 0);
    run_one("b_max", 1'b1, 9999);
    run_one("b_max1", 1'b1, 10000);
    run_one("b_full", 1'b1, 65535);

    // Simultaneous pair: req0 wins first tie after reset, then req1 follows.
    set_req(1'b0, 42);
    set_req(1'b1, 7);
    wait_ack("pairA0", 1'b0, n);
    req0 = 1'b0;
    wait_valid("pairA0", 42, 1'b0, n, bc);
    wait_ack("pairA1", 1'b1, n);
    chk("pairA1_ack_lat", 32'(n), 32'h1);
    req1 = 1'b0;
    wait_valid("pairA1", 7, 1'b1, n, bc);
    tick();

    // Second simultaneous pair alternates, starting with req1.
    va = $urandom_range(0, 65535);
    vb = $urandom_range(0, 9999);
    set_req(1'b0, va);
    set_req(1'b1, vb);
    wait_ack("pairB1", 1'b1, n);
    req1 = 1'b0;
    wait_valid("pairB1", vb, 1'b1, n, bc);
    wait_ack("pairB0", 1'b0, n);
    req0 = 1'b0;
    wait_valid("pairB0", va, 1'b0, n, bc);
    tick();

    // req1 arrives mid-conversion and waits for the next IDLE edge.
    v = $urandom_range(0, 9999);
    set_req(1'b0, v);
    wait_ack("ovl0", 1'b0, n);
    req0 = 1'b0;
    repeat (3) tick();
    set_req(1'b1, 7);
    wait_valid("ovl0", v, 1'b0, n, bc);
    wait_ack("ovl1", 1'b1, n);
    req1 = 1'b0;
    wait_valid("ovl1", 7, 1'b1, n2, bc);
    chk("ovl_spacing", 32'(n + n2), 32'd17);
    tick();

    // Reset in the middle of a conversion discards it.
    set_req(1'b0, 5555);
    wait_ack("rstmid", 1'b0, n);
    req0 = 1'b0;
    repeat (8) tick();
    rst = 1'b1;
    #1;
    chk("rstmid_outputs",
        32'({ack0, ack1, busy, valid, src, ovf, milh, cent, dec, un}), 32'h0);
    tick();
    rst = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (valid) vcnt++;
    end
    chk("rstmid_no_valid", 32'(vcnt), 32'h0);
    run_one("after_rst", 1'b0, 321);

    // A request still high after its ack is a fresh request.
    v = $urandom_range(0, 65535);
    set_req(1'b0, v);
    wait_ack("hold1", 1'b0, n);
    wait_valid("hold1", v, 1'b0, n, bc);
    wait_ack("hold2", 1'b0, n);
    chk("hold2_ack_lat", 32'(n), 32'h1);
    req0 = 1'b0;
    wait_valid("hold2", v, 1'b0, n, bc);
    tick();

    for (int i = 0; i < 6; i++) begin
      who = 1'($urandom_range(0, 1));
      v = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 9999) : $urandom_range(0, 65535);
      run_one("rand", who, v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
